clk_div_bank: RTL



---
 rtl/clk_bank_pkg.sv | 30 +++
 rtl/clk_div_bank_if.sv | 25 ++
 rtl/clk_div_chan.sv | 37 +++
 rtl/clk_div_bank.sv | 114 +++++++++++
 4 files changed

// File: rtl/clk_bank_pkg.sv
// Shared types and helpers for the clock-enable divider bank.
// Config fields are carried at CFG_W bits; narrower DIV_W values are zero-extended.
package clk_bank_pkg;

    localparam int unsigned CFG_W = 16;

    typedef enum logic [1:0] {
        StAlign,
        StSettle,
        StLocked
    } state_e;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] phase;
        logic             en;
    } chan_cfg_t;

    function automatic logic [CFG_W-1:0] div_eff(input logic [CFG_W-1:0] div);
        return (div == '0) ? CFG_W'(1) : div;
    endfunction

    function automatic logic [CFG_W-1:0] phase_clamp(input logic [CFG_W-1:0] phase,
                                                     input logic [CFG_W-1:0] div);
        logic [CFG_W-1:0] de;
        de = div_eff(div);
        return (phase >= de) ? de - CFG_W'(1) : phase;
    endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Config request/accept port of the divider bank.
interface clk_div_bank_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DIV_W  = 8
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;
    logic             cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_en,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: wrapping counter, registered strobe and square wave.
module clk_div_chan
    import clk_bank_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic      refclk,
    input  logic      reset,
    input  logic      align,
    input  chan_cfg_t cfg,
    output logic      ce_out,
    output logic      clk_out
);

    logic [DIV_W-1:0] cnt;
    logic [CFG_W-1:0] cnt_ext;
    logic [CFG_W-1:0] de;
    logic [CFG_W-1:0] half;

    assign cnt_ext = CFG_W'(cnt);
    assign de      = div_eff(cfg.div);
    // ceil(de/2) without overflowing at the top of the range
    assign half    = (de >> 1) + CFG_W'(de[0]);

    always_ff @(posedge refclk) begin
        if (reset || align || !cfg.en) begin
            cnt     <= '0;
            ce_out  <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= (cnt_ext >= de - CFG_W'(1)) ? '0 : cnt + DIV_W'(1);
            ce_out  <= (cnt_ext == cfg.phase);
            clk_out <= (cnt_ext < half);
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Runtime-reconfigurable clock-enable bank: shadow config, align/settle FSM
// and NUM_CH phase-aligned divider channels, all in the refclk domain.
module clk_div_bank
    import clk_bank_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned RST_DIV     = 7,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              reset,
    clk_div_bank_if.slave     bus,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam chan_cfg_t RstCfg = '{div: CFG_W'(RST_DIV), phase: '0, en: 1'b1};

    if (DIV_W > CFG_W) begin : g_bad_width
        $error("DIV_W exceeds the package config width");
    end

    state_e          state;
    logic [SC_W-1:0] settle_cnt;
    logic            ready_q;
    logic            accept;
    logic            hit;
    logic            align;
    chan_cfg_t       new_cfg;
    chan_cfg_t       shadow [NUM_CH];

    assign bus.cfg_ready = ready_q;
    assign accept        = bus.cfg_valid && ready_q;
    // Out-of-range channels are consumed without touching the bank
    assign hit           = accept && (32'(bus.cfg_ch) < NUM_CH);
    assign align         = (state == StAlign);

    always_comb begin
        new_cfg       = RstCfg;
        new_cfg.div   = CFG_W'(bus.cfg_div);
        new_cfg.phase = phase_clamp(CFG_W'(bus.cfg_phase), CFG_W'(bus.cfg_div));
        new_cfg.en    = bus.cfg_en;
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state      <= StAlign;
            settle_cnt <= '0;
            locked     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            unique case (state)
                StAlign: begin
                    state      <= StSettle;
                    settle_cnt <= '0;
                    locked     <= 1'b0;
                    ready_q    <= 1'b0;
                end
                StSettle: begin
                    locked  <= 1'b0;
                    ready_q <= 1'b0;
                    if (settle_cnt == SC_W'(LOCK_CYCLES - 1)) begin
                        state <= StLocked;
                    end else begin
                        settle_cnt <= settle_cnt + SC_W'(1);
                    end
                end
                StLocked: begin
                    if (hit) begin
                        state   <= StAlign;
                        locked  <= 1'b0;
                        ready_q <= 1'b0;
                    end else begin
                        locked  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= StAlign;
                    locked  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                shadow[i] <= RstCfg;
            end else if (hit && (bus.cfg_ch == CH_W'(i))) begin
                shadow[i] <= new_cfg;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_div_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .refclk (refclk),
            .reset  (reset),
            .align  (align),
            .cfg    (shadow[i]),
            .ce_out (ce_out[i]),
            .clk_out(clk_out[i])
        );
    end

endmodule
